// File: rtl/tour_solver.sv
// Backtracking knight's-tour search on a 5x5 board; the resulting tour is kept
// as 24 one-hot moves that the downstream sequencer reads back through indx/move.
module tour_solver (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] x_start,
  input  logic [2:0] y_start,
  input  logic [4:0] indx,
  output logic [7:0] move,
  output logic       done,
  output logic       fail,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for go
  // INIT  | clear board/table, validate start, mark start square
  // POSS  | compute legal-move mask for current level
  // MAKE  | take next untried legal move, or fall through to BACK
  // BACK  | undo the move that led to the current square
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, INIT, POSS, MAKE, BACK, DONE} state_t;

  state_t      state, state_nxt;
  logic [24:0] board;
  logic [7:0]  poss [24];
  logic [7:0]  mv   [24];
  logic [2:0]  x, y;
  logic [4:0]  cnt;

  logic [7:0]  legal, higher, avail, cand, cd, pd, mv_cur, mv_prev;
  logic [2:0]  nx, ny, px, py;
  logic [4:0]  prev_idx;
  logic        bad_start;

  function automatic logic [4:0] sq(input logic [2:0] cx, input logic [2:0] cy);
    return 5'(cy) * 5'd5 + 5'(cx);
  endfunction

  // {dx, dy} as two 4-bit two's-complement nibbles
  function automatic logic [7:0] delta(input logic [7:0] m);
    logic [7:0] d;
    d = 8'h00;
    case (m)
      8'h01:   d = {4'hF, 4'h2};
      8'h02:   d = {4'h1, 4'h2};
      8'h04:   d = {4'hE, 4'h1};
      8'h08:   d = {4'hE, 4'hF};
      8'h10:   d = {4'hF, 4'hE};
      8'h20:   d = {4'h1, 4'hE};
      8'h40:   d = {4'h2, 4'hF};
      8'h80:   d = {4'h2, 4'h1};
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] legal_mask(input logic [2:0] cx, input logic [2:0] cy,
                                            input logic [24:0] brd);
    logic [7:0] lm, d;
    logic [3:0] tx, ty;
    lm = 8'h00;
    for (int b = 0; b < 8; b++) begin
      d  = delta(8'h01 << b);
      tx = {1'b0, cx} + d[7:4];
      ty = {1'b0, cy} + d[3:0];
      if (!tx[3] && tx <= 4'd4 && !ty[3] && ty <= 4'd4)
        lm[b] = !brd[sq(tx[2:0], ty[2:0])];
    end
    return lm;
  endfunction

  always_comb begin
    bad_start = (x > 3'd4) || (y > 3'd4);
    legal     = legal_mask(x, y, board);
    mv_cur    = mv[cnt];
    // mv_cur is one-hot or zero; zero means every legal move is still untried
    higher    = (mv_cur == 8'h00) ? 8'hFF : ~((mv_cur << 1) - 8'd1);
    avail     = poss[cnt] & higher;
    cand      = avail & (~avail + 8'd1);
    cd        = delta(cand);
    nx        = x + cd[6:4];
    ny        = y + cd[2:0];
    prev_idx  = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
    mv_prev   = mv[prev_idx];
    pd        = delta(mv_prev);
    px        = x - pd[6:4];
    py        = y - pd[2:0];
    move      = (indx < 5'd24) ? mv[indx] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (go) state_nxt = INIT;
      INIT: state_nxt = bad_start ? DONE : POSS;
      POSS: state_nxt = MAKE;
      MAKE: begin
        if (cand == 8'h00)      state_nxt = BACK;
        else if (cnt == 5'd23)  state_nxt = DONE;
        else                    state_nxt = POSS;
      end
      BACK: state_nxt = (cnt == 5'd0) ? DONE : MAKE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board <= '0;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      fail  <= 1'b0;
      for (int i = 0; i < 24; i++) begin
        mv[i]   <= 8'h00;
        poss[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: if (go) begin
          x    <= x_start;
          y    <= y_start;
          fail <= 1'b0;
        end
        INIT: begin
          for (int i = 0; i < 24; i++) mv[i] <= 8'h00;
          cnt <= 5'd0;
          if (bad_start) begin
            board <= '0;
            fail  <= 1'b1;
          end else begin
            board <= 25'd1 << sq(x, y);
          end
        end
        POSS: begin
          poss[cnt] <= legal;
          mv[cnt]   <= 8'h00;
        end
        MAKE: if (cand != 8'h00) begin
          mv[cnt]           <= cand;
          x                 <= nx;
          y                 <= ny;
          board[sq(nx, ny)] <= 1'b1;
          if (cnt != 5'd23) cnt <= cnt + 5'd1;
        end
        BACK: begin
          if (cnt == 5'd0) begin
            fail <= 1'b1;
          end else begin
            board[sq(x, y)] <= 1'b0;
            x               <= px;
            y               <= py;
            cnt             <= prev_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
